// File: rtl/ws2812b_frame_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : ws2812b_frame_sequencer_if
// Description : Host register bus plus ws2812b driver handshake for the
//               frame sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
interface ws2812b_frame_sequencer_if;
    logic [3:0]  address;
    logic        data_write;
    logic [7:0]  data_in;
    logic [7:0]  data_out;
    logic [23:0] drv_data;
    logic        drv_valid;
    logic        drv_latch;
    logic        drv_ready;

    modport master (
        output address, data_write, data_in, drv_ready,
        input  data_out, drv_data, drv_valid, drv_latch
    );

    modport slave (
        input  address, data_write, data_in, drv_ready,
        output data_out, drv_data, drv_valid, drv_latch
    );
endinterface
`default_nettype wire

// File: rtl/ws2812b_frame_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : ws2812b_frame_sequencer
// Description : GRB pixel buffer that streams a frame to the ws2812b driver
//               over valid/ready. Optional auto-refresh: WS2812B_SEQ_AUTOREFRESH_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module ws2812b_frame_sequencer #(
    parameter int NUM_PIXELS  = 8,
    parameter int IDX_W       = 3,
    parameter int REFRESH_CYC = 64000
) (
    input  wire logic               clk,
    input  wire logic               reset,
    ws2812b_frame_sequencer_if.slave bus
);

    localparam int         c_LEN_W   = IDX_W + 1;
    localparam logic [7:0] c_MAX_LEN = 8'(NUM_PIXELS);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE   = 2'd1,
        S_WAIT_LO = 2'd2,
        S_WAIT_HI = 2'd3
    } state_t;

    state_t             r_state;
    logic [IDX_W-1:0]   r_ptr;
    logic [IDX_W-1:0]   r_idx;
    logic [c_LEN_W-1:0] r_len;
    logic [7:0]         r_g;
    logic [7:0]         r_r;
    logic [7:0]         r_b;
    logic [23:0]        r_buf [NUM_PIXELS];
    logic               r_done;
    logic               r_err;
    logic [23:0]        r_drv_data;
    logic               r_drv_valid;
    logic               r_drv_latch;

    logic               w_wr_ctrl;
    logic               w_abort;
    logic               w_host_start;
    logic               w_auto_start;
    logic               w_start;
    logic               w_busy;
    logic               w_last;
    logic               w_frame_end;
    logic [7:0]         w_ctrl_rd;
    logic [7:0]         w_rdata;

    assign w_wr_ctrl    = bus.data_write && (bus.address == 4'd1);
    assign w_abort      = w_wr_ctrl && bus.data_in[1];
    assign w_host_start = w_wr_ctrl && bus.data_in[0] && !bus.data_in[1];
    assign w_start      = (w_host_start || w_auto_start) && !w_abort;
    assign w_busy       = (r_state != S_IDLE);
    assign w_last       = ({1'b0, r_ptr} == (r_len - 1'b1));
    assign w_frame_end  = (r_state == S_WAIT_HI) && bus.drv_ready && w_last && !w_abort;

`ifdef WS2812B_SEQ_AUTOREFRESH_EN
    localparam int c_CNT_W = $clog2(REFRESH_CYC + 1);

    logic [c_CNT_W-1:0] r_refresh;
    logic               r_auto;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_refresh <= c_CNT_W'(REFRESH_CYC);
            r_auto    <= 1'b0;
        end else begin
            if (w_wr_ctrl) begin
                r_auto <= bus.data_in[2] && !bus.data_in[1];
            end
            if (w_frame_end) begin
                r_refresh <= c_CNT_W'(REFRESH_CYC);
            end else if (!w_busy && (r_refresh != '0)) begin
                r_refresh <= r_refresh - 1'b1;
            end
        end
    end

    assign w_auto_start = r_auto && (r_refresh == '0) && (r_len != '0) && !w_busy;
    assign w_ctrl_rd    = {5'b0, r_auto, 2'b00};
`else
    assign w_auto_start = 1'b0;
    assign w_ctrl_rd    = 8'h00;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_ptr       <= '0;
            r_idx       <= '0;
            r_len       <= '0;
            r_g         <= '0;
            r_r         <= '0;
            r_b         <= '0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_drv_data  <= '0;
            r_drv_valid <= 1'b0;
            r_drv_latch <= 1'b0;
            for (int i = 0; i < NUM_PIXELS; i++) begin
                r_buf[i] <= '0;
            end
        end else begin
            r_drv_valid <= 1'b0;
            r_drv_latch <= 1'b0;

            if (bus.data_write) begin
                case (bus.address)
                    4'd0: begin
                        r_done <= 1'b0;
                        r_err  <= 1'b0;
                    end
                    4'd2: r_idx <= bus.data_in[IDX_W-1:0];
                    4'd3: r_g   <= bus.data_in;
                    4'd4: r_r   <= bus.data_in;
                    4'd5: begin
                        r_b <= bus.data_in;
                        // The buffer is being read out while busy, so commits are refused.
                        if (w_busy) begin
                            r_err <= 1'b1;
                        end else begin
                            r_buf[r_idx] <= {r_g, r_r, bus.data_in};
                            r_idx        <= r_idx + 1'b1;
                        end
                    end
                    4'd6: r_len <= (bus.data_in > c_MAX_LEN) ? c_MAX_LEN[c_LEN_W-1:0]
                                                              : bus.data_in[c_LEN_W-1:0];
                    default: ;
                endcase
            end

            if (w_host_start && w_busy) begin
                r_err <= 1'b1;
            end

            if (w_abort) begin
                r_state <= S_IDLE;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (w_start) begin
                            if (r_len == '0) begin
                                r_err <= 1'b1;
                            end else begin
                                r_ptr   <= '0;
                                r_state <= S_ISSUE;
                            end
                        end
                    end
                    S_ISSUE: begin
                        if (bus.drv_ready) begin
                            r_drv_data  <= r_buf[r_ptr];
                            r_drv_valid <= 1'b1;
                            r_drv_latch <= w_last;
                            r_state     <= S_WAIT_LO;
                        end
                    end
                    S_WAIT_LO: begin
                        if (!bus.drv_ready) begin
                            r_state <= S_WAIT_HI;
                        end
                    end
                    S_WAIT_HI: begin
                        if (bus.drv_ready) begin
                            if (w_last) begin
                                r_done  <= 1'b1;
                                r_state <= S_IDLE;
                            end else begin
                                r_ptr   <= r_ptr + 1'b1;
                                r_state <= S_ISSUE;
                            end
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    always_comb begin
        w_rdata = 8'h00;
        case (bus.address)
            4'd0:    w_rdata = {5'b0, r_err, r_done, w_busy};
            4'd1:    w_rdata = w_ctrl_rd;
            4'd2:    w_rdata = {{(8-IDX_W){1'b0}}, r_idx};
            4'd3:    w_rdata = r_g;
            4'd4:    w_rdata = r_r;
            4'd5:    w_rdata = r_b;
            4'd6:    w_rdata = {{(8-c_LEN_W){1'b0}}, r_len};
            default: w_rdata = 8'h00;
        endcase
    end

    assign bus.data_out  = w_rdata;
    assign bus.drv_data  = r_drv_data;
    assign bus.drv_valid = r_drv_valid;
    assign bus.drv_latch = r_drv_latch;

endmodule
`default_nettype wire

// File: tb/tb_ws2812b_frame_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_ws2812b_frame_sequencer
// Description : Directed self-checking bench for ws2812b_frame_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_ws2812b_frame_sequencer;

    logic clk = 1'b0;
    logic reset;
    int   tests = 0;
    int   fails = 0;
    int   latch_err = 0;
    int   low_cnt = 0;
    logic [24:0] beat_q [$];

    always #5 clk = ~clk;

    ws2812b_frame_sequencer_if bus ();

    ws2812b_frame_sequencer #(
        .NUM_PIXELS  (8),
        .IDX_W       (3),
        .REFRESH_CYC (100)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    // Driver model: takes a beat, holds ready low for 10 cycles; also logs beats.
    always @(negedge clk) begin
        if (bus.drv_latch && !bus.drv_valid) latch_err++;
        if (bus.drv_valid) beat_q.push_back({bus.drv_latch, bus.drv_data});
        if (reset) begin
            bus.drv_ready = 1'b1;
            low_cnt = 0;
        end else if (low_cnt > 0) begin
            low_cnt--;
            if (low_cnt == 0) bus.drv_ready = 1'b1;
        end else if (bus.drv_valid) begin
            bus.drv_ready = 1'b0;
            low_cnt = 10;
        end
    end

    task automatic tick;
        @(negedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [3:0] a, input logic [7:0] d);
        bus.address    = a;
        bus.data_in    = d;
        bus.data_write = 1'b1;
        tick();
        bus.data_write = 1'b0;
    endtask

    task automatic rd(input logic [3:0] a, output logic [7:0] d);
        bus.address = a;
        tick();
        d = bus.data_out;
    endtask

    task automatic wait_idle(input int bound, output bit ok);
        ok = 1'b0;
        bus.address = 4'd0;
        for (int i = 0; i < bound; i++) begin
            tick();
            if (!bus.data_out[0]) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        logic [7:0] d;
        bit         ok;
        int         n;

        reset          = 1'b1;
        bus.address    = 4'd0;
        bus.data_in    = 8'd0;
        bus.data_write = 1'b0;
        bus.drv_ready  = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        chk("rst_valid", bus.drv_valid, 0);
        chk("rst_latch", bus.drv_latch, 0);
        chk("rst_data", bus.drv_data, 0);
        for (int a = 0; a < 8; a++) begin
            rd(4'(a), d);
            chk("rst_reg", d, 0);
        end

        // Basic three-pixel frame and START-to-valid latency
        wr(2, 8'h00);
        wr(3, 8'h11); wr(4, 8'h22); wr(5, 8'h33);
        wr(3, 8'h44); wr(4, 8'h55); wr(5, 8'h66);
        wr(3, 8'h77); wr(4, 8'h88); wr(5, 8'h99);
        wr(6, 8'd3);
        beat_q.delete();
        wr(1, 8'h01);
        chk("lat_pre", bus.drv_valid, 0);
        tick();
        chk("lat_valid", bus.drv_valid, 1);
        chk("lat_data", bus.drv_data, 32'h112233);
        wait_idle(500, ok);
        chk("t1_timeout", ok, 1);
        chk("t1_beats", beat_q.size(), 3);
        if (beat_q.size() == 3) begin
            chk("t1_beat0", beat_q[0], 32'h0112233);
            chk("t1_beat1", beat_q[1], 32'h0445566);
            chk("t1_beat2", beat_q[2], 32'h1778899);
        end
        rd(0, d);
        chk("t1_status", d, 8'h02);
        wr(0, 8'h00);
        rd(0, d);
        chk("t1_clear", d, 8'h00);

        // IDX wrap from 7 to 0
        wr(2, 8'd7);
        wr(5, 8'hAA);
        wr(5, 8'hBB);
        rd(2, d);
        chk("t2_idx", d, 8'd1);
        wr(6, 8'd8);
        beat_q.delete();
        wr(1, 8'h01);
        wait_idle(1000, ok);
        chk("t2_timeout", ok, 1);
        chk("t2_beats", beat_q.size(), 8);
        if (beat_q.size() == 8) begin
            chk("t2_beat0", beat_q[0], 32'h07788BB);
            chk("t2_beat1", beat_q[1], 32'h0445566);
            chk("t2_beat3", beat_q[3], 32'h0000000);
            chk("t2_beat7", beat_q[7], 32'h17788AA);
        end
        wr(0, 8'h00);

        // START and buffer commit while busy
        wr(6, 8'd3);
        wr(2, 8'd1);
        beat_q.delete();
        wr(1, 8'h01);
        wr(1, 8'h01);
        wr(3, 8'h12);
        wr(5, 8'h00);
        rd(3, d);
        chk("t3_stage_g", d, 8'h12);
        wait_idle(500, ok);
        chk("t3_timeout", ok, 1);
        rd(0, d);
        chk("t3_status", d, 8'h06);
        chk("t3_beats", beat_q.size(), 3);
        if (beat_q.size() == 3) begin
            chk("t3_beat1", beat_q[1], 32'h0445566);
            chk("t3_beat2", beat_q[2], 32'h1778899);
        end
        rd(2, d);
        chk("t3_idx", d, 8'd1);
        wr(0, 8'h00);

        // ABORT after the second beat
        wr(6, 8'd8);
        beat_q.delete();
        wr(1, 8'h01);
        ok = 1'b0;
        for (int i = 0; i < 500; i++) begin
            tick();
            if (beat_q.size() == 2) begin
                ok = 1'b1;
                break;
            end
        end
        chk("t4_two_beats", ok, 1);
        wr(1, 8'h02);
        chk("t4_valid", bus.drv_valid, 0);
        rd(0, d);
        chk("t4_status", d, 8'h00);
        repeat (100) tick();
        chk("t4_beats", beat_q.size(), 2);

        // LEN clamp and START with LEN=0
        wr(6, 8'd20);
        rd(6, d);
        chk("t5_len_clamp", d, 8'd8);
        wr(6, 8'd0);
        beat_q.delete();
        wr(1, 8'h01);
        repeat (20) tick();
        chk("t5_beats", beat_q.size(), 0);
        rd(0, d);
        chk("t5_status", d, 8'h04);
        wr(0, 8'h00);

        // Reset in the middle of a frame
        wr(6, 8'd8);
        wr(3, 8'h5A);
        wr(1, 8'h01);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (bus.drv_valid) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        chk("t6_valid_seen", ok, 1);
        reset = 1'b1;
        tick();
        chk("t6_valid", bus.drv_valid, 0);
        chk("t6_latch", bus.drv_latch, 0);
        chk("t6_data", bus.drv_data, 0);
        rd(0, d); chk("t6_status", d, 0);
        rd(3, d); chk("t6_g", d, 0);
        rd(6, d); chk("t6_len", d, 0);
        rd(2, d); chk("t6_idx", d, 0);
        reset = 1'b0;
        tick();
        wr(6, 8'd1);
        beat_q.delete();
        wr(1, 8'h01);
        wait_idle(200, ok);
        chk("t6_timeout", ok, 1);
        chk("t6_beats", beat_q.size(), 1);
        if (beat_q.size() == 1) chk("t6_buf_clear", beat_q[0], 32'h1000000);
        wr(0, 8'h00);

`ifdef WS2812B_SEQ_AUTOREFRESH_EN
        wr(6, 8'd1);
        wr(1, 8'h05);
        rd(1, d);
        chk("t7_auto_rd", d, 8'h04);
        wait_idle(200, ok);
        chk("t7_timeout", ok, 1);
        n = 0;
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            tick();
            n++;
            if (bus.drv_valid) begin
                ok = 1'b1;
                break;
            end
        end
        chk("t7_restart", ok, 1);
        chk("t7_gap", (n >= 100 && n <= 103), 1);
        wr(1, 8'h02);
        repeat (20) tick();
        beat_q.delete();
        repeat (250) tick();
        chk("t7_abort_auto", beat_q.size(), 0);
`else
        wr(1, 8'h04);
        rd(1, d);
        chk("t7_ctrl_rd", d, 8'h00);
        n = 0;
`endif

        chk("latch_wo_valid", latch_err, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
